// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared encodings for the up/down counter sweep sequencer
package counter_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    TURN   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [1:0] MODE_UP_TO    = 2'd0;
  localparam logic [1:0] MODE_DOWN_TO  = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_RSVD     = 2'd3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - sequences one up/down counter through single or ping-pong sweeps
module counter_sweep_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int W     = 4,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic             cmd_from_preset,
  input  logic [W-1:0]     cmd_target,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             abort,
  input  logic [W-1:0]     cnt_val,
  output logic             cnt_en,
  output logic             cnt_ud,
  output logic             cnt_rst,
  output logic             cnt_preset,
  output logic             cnt_oe,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [REP_W-1:0] legs_left
);

  state_t             state;
  state_t             state_nx;
  logic [1:0]         mode_q;
  logic [W-1:0]       target_q;
  logic [W-1:0]       start_q;
  logic [REP_W-1:0]   reps_q;
  logic               rsvd_q;
  logic [REP_W-1:0]   init_legs;
  logic [W-1:0]       stop;
  logic               at_stop;
  logic               accept;
  logic               last_leg;

  assign accept   = cmd_valid && cmd_ready;
  // Ping-pong down legs return to the start point; every other leg ends on the target.
  assign stop     = (mode_q == MODE_PINGPONG && cnt_ud == DIR_DOWN) ? start_q : target_q;
  assign at_stop  = (cnt_val == stop);
  assign last_leg = (legs_left <= REP_W'(1));
  assign cnt_en   = (state == RUN) && !at_stop && !abort;

  always_comb begin
    init_legs = REP_W'(1);
    if (mode_q == MODE_PINGPONG && reps_q != '0) begin
      init_legs = reps_q;
    end else if (mode_q == MODE_RSVD) begin
      init_legs = '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) state_nx = INIT;
      end
      INIT: begin
        if (abort || mode_q == MODE_RSVD) state_nx = DONE;
        else                              state_nx = SETTLE;
      end
      SETTLE: begin
        state_nx = abort ? DONE : RUN;
      end
      RUN: begin
        if (abort)        state_nx = DONE;
        else if (at_stop) state_nx = last_leg ? DONE : TURN;
      end
      TURN: begin
        state_nx = abort ? DONE : RUN;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      cnt_ud     <= DIR_DOWN;
      cnt_rst    <= 1'b0;
      cnt_preset <= 1'b0;
      cnt_oe     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      legs_left  <= '0;
      mode_q     <= MODE_UP_TO;
      target_q   <= '0;
      start_q    <= '0;
      reps_q     <= '0;
      rsvd_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      // Ready reopens only after a full idle cycle so a fresh accept drops it immediately.
      cmd_ready  <= (state == IDLE) && (state_nx == IDLE);
      busy       <= (state_nx != IDLE);
      cnt_oe     <= (state_nx inside {RUN, TURN, DONE});
      done       <= (state == DONE);
      err        <= (state == DONE) && rsvd_q;
      cnt_rst    <= accept && !cmd_from_preset;
      cnt_preset <= accept && cmd_from_preset;

      if (accept) begin
        mode_q   <= cmd_mode;
        target_q <= cmd_target;
        reps_q   <= cmd_reps;
        start_q  <= cmd_from_preset ? '1 : '0;
        rsvd_q   <= 1'b0;
      end

      if (state == INIT) begin
        legs_left <= init_legs;
        cnt_ud    <= (mode_q == MODE_DOWN_TO) ? DIR_DOWN : DIR_UP;
        rsvd_q    <= (mode_q == MODE_RSVD) && !abort;
      end

      if (state == RUN && state_nx == TURN) begin
        legs_left <= legs_left - REP_W'(1);
        cnt_ud    <= ~cnt_ud;
      end
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb/tb_counter_sweep_ctrl.sv - scoreboard bench for counter_sweep_ctrl with a behavioural counter
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'd0;
  logic       cmd_from_preset = 1'b0;
  logic [3:0] cmd_target = 4'h0;
  logic [7:0] cmd_reps = 8'h0;
  logic       abort = 1'b0;
  logic [3:0] cnt_val = 4'h0;
  logic       cnt_en;
  logic       cnt_ud;
  logic       cnt_rst;
  logic       cnt_preset;
  logic       cnt_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] legs_left;

  typedef struct {
    logic       err;
    logic [3:0] val;
    int         en;
    int         lat;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   en_cnt   = 0;

  always #5 clk = ~clk;

  counter_sweep_ctrl #(.W(4), .REP_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_mode        (cmd_mode),
    .cmd_from_preset (cmd_from_preset),
    .cmd_target      (cmd_target),
    .cmd_reps        (cmd_reps),
    .abort           (abort),
    .cnt_val         (cnt_val),
    .cnt_en          (cnt_en),
    .cnt_ud          (cnt_ud),
    .cnt_rst         (cnt_rst),
    .cnt_preset      (cnt_preset),
    .cnt_oe          (cnt_oe),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .legs_left       (legs_left)
  );

  // Counter datapath: not reset by rst, so it holds across a controller reset.
  always @(posedge clk) begin
    if (cnt_rst)         cnt_val <= 4'h0;
    else if (cnt_preset) cnt_val <= 4'hF;
    else if (cnt_en)     cnt_val <= cnt_ud ? cnt_val + 4'd1 : cnt_val - 4'd1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      en_cnt = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc;
        en_cnt  = 0;
      end
      if (cnt_en) en_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          m_e = sb.pop_front();
          chk($sformatf("%s err", m_e.name), int'(err), int'(m_e.err));
          chk($sformatf("%s final_val", m_e.name), int'(cnt_val), int'(m_e.val));
          chk($sformatf("%s enables", m_e.name), en_cnt, m_e.en);
          chk($sformatf("%s latency", m_e.name), cyc - acc_cyc, m_e.lat);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns one cycle after the accepting edge (cycle a+1).
  task automatic send(input logic [1:0] mode, input logic fp, input logic [3:0] tgt,
                      input logic [7:0] reps, input logic ab, input logic push,
                      input logic e_err, input logic [3:0] e_val, input int e_en,
                      input int e_lat, input string nm);
    int t = 0;
    while (!cmd_ready && t < 100) begin
      step(1);
      t++;
    end
    chk($sformatf("%s ready_before", nm), int'(cmd_ready), 1);
    if (push) sb.push_back('{err: e_err, val: e_val, en: e_en, lat: e_lat, name: nm});
    cmd_valid       = 1'b1;
    cmd_mode        = mode;
    cmd_from_preset = fp;
    cmd_target      = tgt;
    cmd_reps        = reps;
    abort           = ab;
    step(1);
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      step(1);
      t++;
    end
    chk($sformatf("%s drained", nm), sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    chk("reset cmd_ready", int'(cmd_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset cnt_en", int'(cnt_en), 0);
    chk("reset cnt_oe", int'(cnt_oe), 0);
    chk("reset legs_left", int'(legs_left), 0);
    rst = 1'b0;
    step(1);

    // UP_TO 5 from 0: cycle-exact walk from accept (c0)
    send(2'd0, 1'b0, 4'h5, 8'd0, 1'b0, 1'b1, 1'b0, 4'h5, 5, 10, "up5");
    chk("up5 c1 cnt_rst", int'(cnt_rst), 1);
    chk("up5 c1 cmd_ready", int'(cmd_ready), 0);
    chk("up5 c1 busy", int'(busy), 1);
    step(2);
    chk("up5 c3 cnt_en", int'(cnt_en), 1);
    chk("up5 c3 cnt_ud", int'(cnt_ud), 1);
    chk("up5 c3 cnt_oe", int'(cnt_oe), 1);
    chk("up5 c3 legs", int'(legs_left), 1);
    step(5);
    chk("up5 c8 cnt_val", int'(cnt_val), 5);
    chk("up5 c8 cnt_en", int'(cnt_en), 0);
    step(2);
    chk("up5 c10 done", int'(done), 1);
    chk("up5 c10 cmd_ready", int'(cmd_ready), 0);
    step(1);
    chk("up5 c11 cmd_ready", int'(cmd_ready), 1);
    drain("up5");

    send(2'd1, 1'b1, 4'hC, 8'd0, 1'b0, 1'b1, 1'b0, 4'hC, 3, 8, "downC");
    chk("downC c1 cnt_preset", int'(cnt_preset), 1);
    step(2);
    chk("downC c3 cnt_ud", int'(cnt_ud), 0);
    chk("downC c3 cnt_val", int'(cnt_val), 15);
    drain("downC");

    send(2'd2, 1'b0, 4'h3, 8'd3, 1'b0, 1'b1, 1'b0, 4'h3, 9, 18, "pp3");
    step(2);
    chk("pp3 leg1 legs", int'(legs_left), 3);
    chk("pp3 leg1 ud", int'(cnt_ud), 1);
    step(4);
    chk("pp3 turn1 cnt_en", int'(cnt_en), 0);
    chk("pp3 turn1 ud", int'(cnt_ud), 0);
    chk("pp3 turn1 legs", int'(legs_left), 2);
    chk("pp3 turn1 val", int'(cnt_val), 3);
    step(1);
    chk("pp3 leg2 cnt_en", int'(cnt_en), 1);
    step(4);
    chk("pp3 turn2 cnt_en", int'(cnt_en), 0);
    chk("pp3 turn2 ud", int'(cnt_ud), 1);
    chk("pp3 turn2 legs", int'(legs_left), 1);
    chk("pp3 turn2 val", int'(cnt_val), 0);
    drain("pp3");

    send(2'd0, 1'b1, 4'h2, 8'd0, 1'b0, 1'b1, 1'b0, 4'h2, 3, 8, "wrap");
    drain("wrap");

    send(2'd0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1, 1'b0, 4'h0, 0, 5, "zero");
    step(2);
    chk("zero c3 cnt_en", int'(cnt_en), 0);
    drain("zero");

    send(2'd0, 1'b0, 4'hE, 8'd0, 1'b0, 1'b1, 1'b0, 4'h6, 6, 11, "abort");
    step(8);
    chk("abort val_before", int'(cnt_val), 6);
    abort = 1'b1;
    #1;
    chk("abort cnt_en", int'(cnt_en), 0);
    step(1);
    abort = 1'b0;
    chk("abort val_hold", int'(cnt_val), 6);
    drain("abort");

    // reserved mode, with abort coinciding with the accept (accept wins)
    send(2'd3, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 1'b1, 4'h0, 0, 3, "rsvd");
    drain("rsvd");

    send(2'd2, 1'b0, 4'h3, 8'd3, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, "pp_rst");
    step(4);
    chk("pp_rst val_before", int'(cnt_val), 2);
    chk("pp_rst en_before", int'(cnt_en), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("pp_rst busy", int'(busy), 0);
    chk("pp_rst cmd_ready", int'(cmd_ready), 1);
    chk("pp_rst cnt_en", int'(cnt_en), 0);
    chk("pp_rst cnt_oe", int'(cnt_oe), 0);
    chk("pp_rst val_kept", int'(cnt_val), 3);

    send(2'd0, 1'b0, 4'h1, 8'd0, 1'b0, 1'b1, 1'b0, 4'h1, 1, 6, "after_rst");
    drain("after_rst");

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
